// File: rtl/tile_cfg_bank_loader.sv
// Memory-bank configuration sequencer for one tile: streams DATA_W-bit words into the
// tile's flattened bl/wl config array with programmable bit-line setup and word-line pulse.
module tile_cfg_bank_loader #(
    parameter int NUM_BITS  = 158,
    parameter int DATA_W    = 8,
    parameter int SETUP_CYC = 1,
    parameter int WL_PULSE  = 2,
    parameter int CNT_W     = 8
) (
    input  logic                prog_clk,
    input  logic                prog_reset_n,
    input  logic                cfg_start,
    input  logic                cfg_abort,
    input  logic                bs_valid,
    output logic                bs_ready,
    input  logic [DATA_W-1:0]   bs_data,
    input  logic                bs_last,
    output logic [NUM_BITS-1:0] bl,
    output logic [NUM_BITS-1:0] wl,
    output logic                cfg_busy,
    output logic                cfg_done,
    output logic                cfg_err,
    output logic [CNT_W-1:0]    word_cnt
);

    localparam int NUM_WORDS = (NUM_BITS + DATA_W - 1) / DATA_W;
    localparam int ADDR_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int PH_MAX    = (SETUP_CYC > WL_PULSE) ? SETUP_CYC : WL_PULSE;
    localparam int PH_W      = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);
    localparam logic [PH_W-1:0]   SETUP_END = PH_W'(SETUP_CYC - 1);
    localparam logic [PH_W-1:0]   PULSE_END = PH_W'(WL_PULSE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SETUP,
        S_PULSE,
        S_HOLD
    } state_t;

    state_t               r_state;
    logic [ADDR_W-1:0]    r_addr;
    logic [PH_W-1:0]      r_ph;
    logic                 r_last;
    logic [NUM_BITS-1:0]  r_bl;
    logic [NUM_BITS-1:0]  r_wl;
    logic                 r_done;
    logic                 r_err;
    logic [CNT_W-1:0]     r_cnt;

    state_t               w_state_nxt;
    logic [ADDR_W-1:0]    w_addr_nxt;
    logic [PH_W-1:0]      w_ph_nxt;
    logic                 w_last_nxt;
    logic [NUM_BITS-1:0]  w_bl_nxt;
    logic [NUM_BITS-1:0]  w_wl_nxt;
    logic                 w_done_nxt;
    logic                 w_err_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;

    logic [NUM_BITS-1:0]  w_slice_data;
    logic [NUM_BITS-1:0]  w_slice_mask;

    // Shifting a NUM_BITS-wide copy drops the tail of the final partial slice for free.
    assign w_slice_data = NUM_BITS'(bs_data) << (int'(r_addr) * DATA_W);
    assign w_slice_mask = NUM_BITS'({DATA_W{1'b1}}) << (int'(r_addr) * DATA_W);

    // NOTE: every signal gets its hold value before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_ph_nxt    = r_ph;
        w_last_nxt  = r_last;
        w_bl_nxt    = r_bl;
        w_wl_nxt    = r_wl;
        w_done_nxt  = r_done;
        w_err_nxt   = r_err;
        w_cnt_nxt   = r_cnt;

        if (r_state != S_IDLE && cfg_abort) begin
            w_state_nxt = S_IDLE;
            w_bl_nxt    = '0;
            w_wl_nxt    = '0;
            w_done_nxt  = 1'b0;
            w_err_nxt   = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_bl_nxt = '0;
                    w_wl_nxt = '0;
                    if (cfg_start && !cfg_abort) begin
                        w_state_nxt = S_FETCH;
                        w_addr_nxt  = '0;
                        w_done_nxt  = 1'b0;
                        w_err_nxt   = 1'b0;
                        w_cnt_nxt   = '0;
                    end
                end
                S_FETCH: begin
                    if (bs_valid) begin
                        w_state_nxt = S_SETUP;
                        w_bl_nxt    = w_slice_data;
                        w_last_nxt  = bs_last;
                        w_ph_nxt    = '0;
                    end
                end
                S_SETUP: begin
                    if (r_ph == SETUP_END) begin
                        w_state_nxt = S_PULSE;
                        w_wl_nxt    = w_slice_mask;
                        w_ph_nxt    = '0;
                    end else begin
                        w_ph_nxt = r_ph + 1'b1;
                    end
                end
                S_PULSE: begin
                    if (r_ph == PULSE_END) begin
                        w_state_nxt = S_HOLD;
                        w_wl_nxt    = '0;
                    end else begin
                        w_ph_nxt = r_ph + 1'b1;
                    end
                end
                S_HOLD: begin
                    // bl is released only here, one cycle after wl has already fallen.
                    w_bl_nxt  = '0;
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_addr == LAST_ADDR || r_last) begin
                        w_state_nxt = S_IDLE;
                        if (r_addr == LAST_ADDR && r_last) begin
                            w_done_nxt = 1'b1;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end else begin
                        w_state_nxt = S_FETCH;
                        w_addr_nxt  = r_addr + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_bl_nxt    = '0;
                    w_wl_nxt    = '0;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of statement order.
    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_ph    <= '0;
            r_last  <= 1'b0;
            r_bl    <= '0;
            r_wl    <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_addr  <= w_addr_nxt;
            r_ph    <= w_ph_nxt;
            r_last  <= w_last_nxt;
            r_bl    <= w_bl_nxt;
            r_wl    <= w_wl_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign bs_ready = (r_state == S_FETCH);
    assign cfg_busy = (r_state != S_IDLE);
    assign bl       = r_bl;
    assign wl       = r_wl;
    assign cfg_done = r_done;
    assign cfg_err  = r_err;
    assign word_cnt = r_cnt;

endmodule
